agu: RTL and testbench



---
 rtl/agu.sv | 55 +++++
 tb/tb_agu.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/agu.sv
// Radix-2 in-place FFT address generator.
// Each cycle the butterfly operand addresses and twiddle index are derived
// purely from the presented stage/pair_id and registered (1-cycle latency).
module agu #(
  parameter  int N  = 32,
  localparam int AW = $clog2(N),
  localparam int PW = $clog2(N / 2),
  localparam int SW = $clog2(AW)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [SW-1:0] stage,
  input  logic [PW-1:0] pair_id,
  output logic [AW-1:0] address1,
  output logic [AW-1:0] address2,
  output logic [AW-1:0] twiddle_address
);

  logic [AW-1:0] pair_ext;
  logic [AW-1:0] low_mask;
  logic [AW-1:0] span_bit;
  logic [AW-1:0] a1_next;
  logic [AW-1:0] a2_next;
  logic [AW-1:0] tw_next;

  // Insert a zero at bit `stage` of pair_id; twiddle is the low part
  // left-justified just below the MSB. Out-of-range stages produce zeros.
  always_comb begin
    pair_ext = AW'(pair_id);
    span_bit = AW'(1) << stage;
    low_mask = span_bit - AW'(1);
    a1_next  = ((pair_ext & ~low_mask) << 1) | (pair_ext & low_mask);
    a2_next  = a1_next | span_bit;
    tw_next  = (pair_ext & low_mask) << (SW'(AW - 1) - stage);
    if (stage > SW'(AW - 1)) begin
      a1_next = '0;
      a2_next = '0;
      tw_next = '0;
    end
  end

  // Output registers, cleared asynchronously while reset is low.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      address1        <= '0;
      address2        <= '0;
      twiddle_address <= '0;
    end else begin
      address1        <= a1_next;
      address2        <= a2_next;
      twiddle_address <= tw_next;
    end
  end

endmodule

// File: tb/tb_agu.sv
// Self-checking bench for agu (N=32): directed table, latency/coverage
// sweep, random stimulus and asynchronous reset sequences.
module tb_agu;

  localparam int N  = 32;
  localparam int AW = 5;

  logic       clk;
  logic       reset;
  logic [2:0] stage;
  logic [3:0] pair_id;
  logic [4:0] address1;
  logic [4:0] address2;
  logic [4:0] twiddle_address;

  int checks;
  int passes;

  agu #(.N(N)) dut (
    .clk             (clk),
    .reset           (reset),
    .stage           (stage),
    .pair_id         (pair_id),
    .address1        (address1),
    .address2        (address2),
    .twiddle_address (twiddle_address)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int st;
    int pr;
    int e1;
    int e2;
    int et;
  } vec_t;

  // Expected outputs from the arithmetic definition of the butterfly.
  function automatic void model(input int s, input int p,
                                output int a1, output int a2, output int tw);
    int span;
    if (s > AW - 1) begin
      a1 = 0; a2 = 0; tw = 0;
    end else begin
      span = 1 << s;
      a1 = (p / span) * (2 * span) + (p % span);
      a2 = a1 + span;
      tw = (p % span) * (1 << (AW - 1 - s));
    end
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic check_outs(input string name, input int e1, input int e2, input int et);
    check({name, ".address1"}, 32'(address1), 32'(e1));
    check({name, ".address2"}, 32'(address2), 32'(e2));
    check({name, ".twiddle"}, 32'(twiddle_address), 32'(et));
  endtask

  vec_t vecs[8];
  int   cnt[5][32];

  initial begin
    int e1, e2, et;
    int ps, pp;
    int idx;
    checks = 0;
    passes = 0;

    vecs[0] = '{1, 3, 5, 7, 8};
    vecs[1] = '{2, 5, 9, 13, 4};
    vecs[2] = '{4, 15, 15, 31, 15};
    vecs[3] = '{4, 0, 0, 16, 0};
    vecs[4] = '{3, 6, 6, 14, 12};
    vecs[5] = '{0, 15, 30, 31, 0};
    vecs[6] = '{6, 9, 0, 0, 0};
    vecs[7] = '{5, 15, 0, 0, 0};

    // Reset held low: outputs must stay zero across clock edges.
    reset   = 1'b0;
    stage   = 3'd0;
    pair_id = 4'd5;
    #1;
    check_outs("reset_async", 0, 0, 0);
    repeat (3) @(posedge clk);
    #1;
    check_outs("reset_held", 0, 0, 0);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check_outs("after_release", 10, 11, 0);

    // Directed table.
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      stage   = 3'(vecs[i].st);
      pair_id = 4'(vecs[i].pr);
      @(posedge clk);
      #1;
      check_outs($sformatf("vec%0d", i), vecs[i].e1, vecs[i].e2, vecs[i].et);
    end

    // Sweep with new inputs every cycle; outputs must track previous inputs.
    for (int s = 0; s < 5; s++)
      for (int a = 0; a < 32; a++) cnt[s][a] = 0;
    @(negedge clk);
    stage   = 3'd0;
    pair_id = 4'd0;
    idx     = 0;
    for (int c = 0; c < 80; c++) begin
      @(posedge clk);
      #1;
      ps = int'(stage);
      pp = int'(pair_id);
      idx++;
      if (idx < 80) begin
        stage   = 3'(idx / 16);
        pair_id = 4'(idx % 16);
      end
      #1;
      model(ps, pp, e1, e2, et);
      check_outs($sformatf("sweep_s%0d_p%0d", ps, pp), e1, e2, et);
      check($sformatf("span_s%0d_p%0d", ps, pp), 32'(int'(address2) - int'(address1)), 32'(1 << ps));
      cnt[ps][address1]++;
      cnt[ps][address2]++;
    end
    for (int s = 0; s < 5; s++)
      for (int a = 0; a < 32; a++)
        check($sformatf("cover_s%0d_a%0d", s, a), 32'(cnt[s][a]), 32'd1);

    // Random stimulus, including out-of-range stages.
    @(negedge clk);
    stage   = 3'($urandom_range(0, 7));
    pair_id = 4'($urandom_range(0, 15));
    for (int c = 0; c < 200; c++) begin
      @(posedge clk);
      #1;
      ps = int'(stage);
      pp = int'(pair_id);
      stage   = 3'($urandom_range(0, 7));
      pair_id = 4'($urandom_range(0, 15));
      #1;
      model(ps, pp, e1, e2, et);
      check_outs($sformatf("rand%0d_s%0d_p%0d", c, ps, pp), e1, e2, et);
    end

    // Mid-sequence reset zeroes outputs before the next edge.
    @(negedge clk);
    stage   = 3'd3;
    pair_id = 4'd7;
    @(posedge clk);
    #1;
    check_outs("pre_midreset", 7, 15, 14);
    #2;
    reset = 1'b0;
    #1;
    check_outs("midreset_async", 0, 0, 0);
    @(posedge clk);
    #1;
    check_outs("midreset_held", 0, 0, 0);
    stage   = 3'd2;
    pair_id = 4'd5;
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check_outs("midreset_resume", 9, 13, 4);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
